// File: rtl/mac_collector_pkg.sv
// pe_array_pkg: shared constants and result types for the PE array datapath
package pe_array_pkg;

    localparam int array_width_def = 8;
    localparam int mac_w_def       = 32;

    typedef logic [mac_w_def-1:0] mac_t;
    typedef mac_t [array_width_def-1:0] mac_row_t;

endpackage

// File: rtl/mac_collector_lane_fifo.sv
// lane_fifo: single-column result queue with same-cycle push/pop on a full queue
module lane_fifo
    import pe_array_pkg::*;
#(
    parameter int depth = 8,
    parameter int w     = mac_w_def
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  logic [w-1:0] data_i,
    output logic [w-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [aw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cw-1:0] cnt_q, cnt_d;
    logic [w-1:0]  mem_q [depth];
    logic [w-1:0]  mem_d [depth];
    logic          wr, rd;

    assign head_o = mem_q[rptr_q];

    // a full lane still accepts a push when it is popped in the same cycle
    always_comb begin
        full_o  = cnt_q == cw'(depth);
        empty_o = cnt_q == '0;
        wr      = push_i && (!full_o || pop_i) && !clear_i;
        rd      = pop_i && !empty_o && !clear_i;
        wptr_d  = clear_i ? '0 : wptr_q + aw'(wr);
        rptr_d  = clear_i ? '0 : rptr_q + aw'(rd);
        cnt_d   = clear_i ? '0 : cnt_q + cw'(wr) - cw'(rd);
        mem_d   = mem_q;
        if (wr) mem_d[wptr_q] = data_i;
    end

    // pointer and occupancy state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // storage carries no reset; contents behind an empty count are don't-care
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mac_collector.sv
// mac_collector: realigns skewed per-column MAC results into full rows on a valid/ready stream
module mac_collector
    import pe_array_pkg::*;
#(
    parameter int array_width = array_width_def,
    parameter int mac_w       = mac_w_def,
    parameter int lane_depth  = 8,
    parameter int row_cnt_w   = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [array_width-1:0][mac_w-1:0] mac_i,
    input  logic [array_width-1:0]            mac_v_i,
    input  logic [row_cnt_w-1:0]              rows_i,
    input  logic                              clear_i,
    output logic [array_width-1:0][mac_w-1:0] row_o,
    output logic                              row_v_o,
    input  logic                              row_ready_i,
    output logic                              row_last_o,
    output logic                              overflow_o,
    output logic                              busy_o
);

    logic [array_width-1:0][mac_w-1:0] head;
    logic [array_width-1:0]            full, empty;
    logic [row_cnt_w-1:0]              cnt_q, cnt_d;
    logic                              ovf_q, ovf_d;
    logic                              hs, last_hit;

    for (genvar j = 0; j < array_width; j++) begin : g_lane
        lane_fifo #(.depth(lane_depth), .w(mac_w)) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (mac_v_i[j]),
            .pop_i   (hs),
            .clear_i (clear_i),
            .data_i  (mac_i[j]),
            .head_o  (head[j]),
            .full_o  (full[j]),
            .empty_o (empty[j])
        );
        assign row_o[j] = row_v_o ? head[j] : '0;
    end

    // row assembly, frame counting and sticky drop detection
    always_comb begin
        row_v_o    = &(~empty);
        busy_o     = |(~empty);
        hs         = row_v_o && row_ready_i;
        last_hit   = rows_i != '0 && cnt_q == rows_i - row_cnt_w'(1);
        row_last_o = row_v_o && last_hit;
        overflow_o = ovf_q;
        cnt_d      = clear_i ? '0 : !hs ? cnt_q : last_hit ? '0 : cnt_q + row_cnt_w'(1);
        ovf_d      = clear_i ? 1'b0 : ovf_q || |(mac_v_i & full & ~{array_width{hs}});
    end

    // row counter and overflow flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_collector.sv
// tb_mac_collector: directed and randomized checks against a queue-based reference model
module tb_mac_collector;
    import pe_array_pkg::*;

    localparam int aw = 8;
    localparam int ld = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    mac_row_t       mac;
    logic [aw-1:0]  mac_v;
    logic [15:0]    rows;
    logic           clr, rdy;
    mac_row_t       row;
    logic           row_v, last, ovf, busy;

    int             checks = 0;
    int             errors = 0;
    int unsigned    mq [aw][$];
    int unsigned    mcnt = 0;
    bit             movf = 1'b0;

    always #5 clk = ~clk;

    mac_collector dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .mac_i       (mac),
        .mac_v_i     (mac_v),
        .rows_i      (rows),
        .clear_i     (clr),
        .row_o       (row),
        .row_v_o     (row_v),
        .row_ready_i (rdy),
        .row_last_o  (last),
        .overflow_o  (ovf),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_valid();
        for (int j = 0; j < aw; j++) if (mq[j].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_busy();
        for (int j = 0; j < aw; j++) if (mq[j].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_last();
        return m_valid() && rows != 0 && mcnt == rows - 1;
    endfunction

    task automatic m_reset();
        for (int j = 0; j < aw; j++) mq[j].delete();
        mcnt = 0;
        movf = 1'b0;
    endtask

    task automatic compare();
        logic [255:0] er;
        bit v;
        v  = m_valid();
        er = '0;
        if (v) for (int j = 0; j < aw; j++) er[j*32 +: 32] = mq[j][0];
        chk("row_v", row_v, v);
        chk("row", row, er);
        chk("row_last", last, m_last());
        chk("overflow", ovf, movf);
        chk("busy", busy, m_busy());
    endtask

    task automatic m_update();
        bit hs, lh;
        hs = m_valid() && rdy;
        lh = m_last();
        if (clr) begin
            m_reset();
            return;
        end
        for (int j = 0; j < aw; j++) begin
            bit acc;
            acc = mac_v[j] && (mq[j].size() < ld || hs);
            if (mac_v[j] && !acc) movf = 1'b1;
            if (hs) void'(mq[j].pop_front());
            if (acc) mq[j].push_back(mac[j]);
        end
        if (hs) mcnt = lh ? 0 : (mcnt + 1) % 65536;
    endtask

    task automatic tick();
        #1 compare();
        m_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic [aw-1:0] v, input int unsigned base, input int unsigned stride,
                         input logic r, input logic c);
        mac_v = v;
        for (int j = 0; j < aw; j++) mac[j] = base + j * stride;
        rdy = r;
        clr = c;
    endtask

    initial begin
        drive('0, 0, 1, 1'b0, 1'b0);
        rows = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_row_v", row_v, 1'b0);
        chk("rst_row", row, '0);
        chk("rst_last", last, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        m_reset();
        tick();

        for (int c = 0; c < aw; c++) begin
            drive(aw'(1) << c, 100, 1, 1'b1, 1'b0);
            tick();
        end
        drive('0, 0, 1, 1'b1, 1'b0);
        #1 chk("skew_v", row_v, 1'b1);
        chk("skew_col3", row[3], 32'd103);
        chk("skew_col7", row[7], 32'd107);
        tick();
        chk("skew_busy", busy, 1'b0);

        for (int r = 0; r < 3; r++) begin
            drive('1, 200 + r * 8, 1, 1'b0, 1'b0);
            tick();
        end
        drive('0, 0, 1, 1'b0, 1'b0);
        tick();
        chk("bp_hold_v", row_v, 1'b1);
        chk("bp_hold_row", row[0], 32'd200);
        for (int r = 0; r < 3; r++) begin
            drive('0, 0, 1, 1'b1, 1'b0);
            #1 chk("bp_row", row[0], 200 + r * 8);
            tick();
        end
        chk("bp_busy", busy, 1'b0);

        for (int i = 0; i < 9; i++) begin
            drive(8'h01, 300 + i, 0, 1'b0, 1'b0);
            tick();
            if (i == 7) chk("ovf_pre", ovf, 1'b0);
        end
        drive('0, 0, 1, 1'b0, 1'b0);
        #1 chk("ovf_set", ovf, 1'b1);
        for (int k = 0; k < ld; k++) begin
            drive(8'hFE, 500, 1, 1'b1, 1'b0);
            tick();
            chk("ovf_lane0", row[0], 300 + k);
        end
        drive('0, 0, 1, 1'b1, 1'b0);
        tick();
        drive('0, 0, 1, 1'b0, 1'b1);
        tick();
        chk("clr_ovf", ovf, 1'b0);
        chk("clr_busy", busy, 1'b0);

        rows = 16'd3;
        for (int r = 0; r < 7; r++) begin
            drive('1, 600 + r * 8, 1, 1'b1, 1'b0);
            tick();
            chk("frame_last", last, (r % 3) == 2);
        end
        drive('0, 0, 1, 1'b1, 1'b0);
        tick();
        rows = '0;

        for (int r = 0; r < ld; r++) begin
            drive('1, 400 + r * 8, 1, 1'b0, 1'b0);
            tick();
        end
        drive('1, 400 + ld * 8, 1, 1'b1, 1'b0);
        tick();
        chk("full_pp_ovf", ovf, 1'b0);
        for (int r = 1; r <= ld; r++) begin
            drive('0, 0, 1, 1'b1, 1'b0);
            #1 chk("full_pp_order", row[0], 400 + r * 8);
            tick();
        end
        chk("full_pp_busy", busy, 1'b0);

        for (int r = 0; r < 2; r++) begin
            drive('1, 700 + r * 8, 1, 1'b0, 1'b0);
            tick();
        end
        #2 rst_n = 1'b0;
        #1 chk("arst_row_v", row_v, 1'b0);
        chk("arst_row", row, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_last", last, 1'b0);
        m_reset();
        drive('0, 0, 1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive('1, 7, 0, 1'b0, 1'b0);
        tick();
        chk("arst_fresh", row, {aw{32'd7}});
        drive('0, 0, 1, 1'b1, 1'b0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            if (!m_busy() && $urandom_range(3) == 0) rows = 16'($urandom_range(4));
            mac_v = aw'($urandom) | aw'($urandom);
            for (int j = 0; j < aw; j++) mac[j] = $urandom;
            rdy = $urandom_range(2) != 0;
            clr = $urandom_range(99) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
